// File: rtl/ttt_pkg.sv
// Shared types and constants for the tictactoe board-scan receiver.
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10,
        BAD   = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        XWIN = 2'b01,
        OWIN = 2'b10,
        DRAW = 2'b11
    } win_t;

    typedef enum logic {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

    localparam int unsigned NCELLS  = 9;
    localparam int unsigned BOARD_W = 2 * NCELLS;
    localparam logic [1:0]  IDLE_RC = 2'b11;

endpackage

// File: rtl/ttt_board_check.sv
// Combinational frame consistency check: X/O balance and winner piece count.
module ttt_board_check
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  logic [1:0]         win,
    output logic               bad
);

    logic [3:0] x_cnt;
    logic [3:0] o_cnt;
    logic [3:0] diff;

    always_comb begin
        x_cnt = '0;
        o_cnt = '0;
        for (int unsigned i = 0; i < NCELLS; i++) begin
            if (board[2*i +: 2] == X) x_cnt = x_cnt + 4'd1;
            if (board[2*i +: 2] == O) o_cnt = o_cnt + 4'd1;
        end
        diff = (x_cnt >= o_cnt) ? (x_cnt - o_cnt) : (o_cnt - x_cnt);
        bad  = (diff > 4'd1)
            || ((win == XWIN) && (x_cnt < 4'd3))
            || ((win == OWIN) && (o_cnt < 4'd3));
    end

endmodule

// File: rtl/ttt_board_rx.sv
// Rebuilds the 3x3 board from the core's row-major cell scan and publishes each
// complete frame through a valid/ready snapshot. Option: TTT_BOARD_RX_CHECK_EN.
module ttt_board_rx
    import ttt_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic [1:0]         xoro_in,
    input  logic [1:0]         row_in,
    input  logic [1:0]         col_in,
    input  logic [1:0]         win_in,
    output logic               snap_valid,
    input  logic               snap_ready,
    output logic [BOARD_W-1:0] snap_board,
    output logic [1:0]         snap_win,
    output logic               snap_bad,
    output logic               seq_err,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(NCELLS - 1);

    rx_state_t          state_q, state_d;
    logic [3:0]         exp_q, exp_d;
    logic [BOARD_W-1:0] shadow_q, shadow_d;
    logic               snap_valid_q, snap_valid_d;
    logic [BOARD_W-1:0] snap_board_q, snap_board_d;
    logic [1:0]         snap_win_q, snap_win_d;
    logic               seq_err_q, seq_err_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               idle;
    logic               legal;
    logic               origin;
    logic [3:0]         idx;
    logic [BOARD_W-1:0] merged;
    logic               complete;
    logic               load;

    assign idle   = (row_in == IDLE_RC) || (col_in == IDLE_RC);
    assign legal  = (xoro_in != BAD);
    assign idx    = ({2'b00, row_in} * 4'd3) + {2'b00, col_in};
    assign origin = (idx == 4'd0);

    // Shadow with the current cell written in; for (2,2) this is the finished frame.
    always_comb begin
        merged = shadow_q;
        if (!idle) merged[{idx, 1'b0} +: 2] = xoro_in;
    end

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        shadow_d     = shadow_q;
        seq_err_d    = 1'b0;
        snap_valid_d = snap_valid_q;
        snap_board_d = snap_board_q;
        snap_win_d   = snap_win_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        complete     = 1'b0;
        load         = 1'b0;

        if (snap_valid_q && snap_ready) snap_valid_d = 1'b0;

        if (!idle) begin
            unique case (state_q)
                SYNC: begin
                    if (origin && legal) begin
                        shadow_d      = '0;
                        shadow_d[1:0] = xoro_in;
                        exp_d         = 4'd1;
                        state_d       = COLLECT;
                    end
                end
                COLLECT: begin
                    if ((idx == exp_q) && legal) begin
                        if (idx == LAST_IDX) begin
                            complete = 1'b1;
                        end else begin
                            shadow_d = merged;
                            exp_d    = exp_q + 4'd1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        shadow_d  = '0;
                        exp_d     = 4'd0;
                        state_d   = SYNC;
                        // A legal (0,0) that breaks the order still starts a new frame.
                        if (origin && legal) begin
                            shadow_d[1:0] = xoro_in;
                            exp_d         = 4'd1;
                            state_d       = COLLECT;
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        if (complete) begin
            shadow_d = '0;
            exp_d    = 4'd0;
            state_d  = SYNC;
            if (!snap_valid_q || snap_ready) begin
                load         = 1'b1;
                snap_board_d = merged;
                snap_win_d   = win_in;
                snap_valid_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q      <= SYNC;
            exp_q        <= '0;
            shadow_q     <= '0;
            snap_valid_q <= 1'b0;
            snap_board_q <= '0;
            snap_win_q   <= '0;
            seq_err_q    <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            shadow_q     <= shadow_d;
            snap_valid_q <= snap_valid_d;
            snap_board_q <= snap_board_d;
            snap_win_q   <= snap_win_d;
            seq_err_q    <= seq_err_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

`ifdef TTT_BOARD_RX_CHECK_EN
    logic chk_bad;
    logic snap_bad_q, snap_bad_d;

    ttt_board_check u_check (
        .board (merged),
        .win   (win_in),
        .bad   (chk_bad)
    );

    always_comb begin
        snap_bad_d = snap_bad_q;
        if (load) snap_bad_d = chk_bad;
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) snap_bad_q <= 1'b0;
        else        snap_bad_q <= snap_bad_d;
    end

    assign snap_bad = snap_bad_q;
`else
    assign snap_bad = 1'b0;
`endif

    assign snap_valid = snap_valid_q;
    assign snap_board = snap_board_q;
    assign snap_win   = snap_win_q;
    assign seq_err    = seq_err_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ttt_board_rx.sv
// Self-checking bench for ttt_board_rx: directed vector table, hand sequences,
// and randomized scans against a queue-based frame model.
module tb_ttt_board_rx;

    localparam int CNT_W = 8;

    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  xoro_in = 2'b00;
    logic [1:0]  row_in = 2'b11;
    logic [1:0]  col_in = 2'b11;
    logic [1:0]  win_in = 2'b00;
    logic        snap_ready = 1'b0;
    logic        snap_valid;
    logic [17:0] snap_board;
    logic [1:0]  snap_win;
    logic        snap_bad;
    logic        seq_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] drop_cnt;

    ttt_board_rx #(.CNT_W(CNT_W)) dut (
        .ph1        (ph1),
        .reset      (reset),
        .xoro_in    (xoro_in),
        .row_in     (row_in),
        .col_in     (col_in),
        .win_in     (win_in),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_board (snap_board),
        .snap_win   (snap_win),
        .snap_bad   (snap_bad),
        .seq_err    (seq_err),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 ph1 = ~ph1;

    int total = 0;
    int bad = 0;

    logic [17:0] board_a;
    logic [17:0] board_b;
    logic [17:0] board_x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        logic [1:0]  row, col, xoro, win;
        bit          ready;
        bit          e_valid;
        logic [17:0] e_board;
        logic [1:0]  e_win;
        bit          e_err;
        logic [7:0]  e_frame, e_drop;
    } vec_t;

    vec_t vecs[$];
    bit          ev;
    logic [17:0] eb;
    logic [1:0]  ew;
    logic [7:0]  ef, ed;

    task automatic push(input bit rst, input logic [1:0] row, input logic [1:0] col,
                        input logic [1:0] xoro, input logic [1:0] win, input bit ready, input bit err);
        vec_t v;
        v.rst = rst; v.row = row; v.col = col; v.xoro = xoro; v.win = win; v.ready = ready;
        v.e_valid = ev; v.e_board = eb; v.e_win = ew; v.e_err = err; v.e_frame = ef; v.e_drop = ed;
        vecs.push_back(v);
    endtask

    task automatic push_rst();
        ev = 1'b0; eb = '0; ew = 2'b00; ef = 8'd0; ed = 8'd0;
        push(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic push_cell(input int idx, input logic [1:0] code, input logic [1:0] win,
                             input bit ready, input bit err);
        push(1'b0, 2'(idx / 3), 2'(idx % 3), code, win, ready, err);
    endtask

    task automatic push_idle(input logic [1:0] row, input logic [1:0] col, input bit ready);
        push(1'b0, row, col, 2'b00, 2'b00, ready, 1'b0);
    endtask

    // Cells 0..7 leave the snapshot as it was; cell 8 produces the given new state.
    task automatic push_frame(input logic [17:0] brd, input logic [1:0] win, input bit ready_last,
                              input bit n_ev, input logic [17:0] n_eb, input logic [1:0] n_ew,
                              input logic [7:0] n_ef, input logic [7:0] n_ed);
        for (int i = 0; i < 8; i++) push_cell(i, brd[2*i +: 2], 2'b00, 1'b0, 1'b0);
        ev = n_ev; eb = n_eb; ew = n_ew; ef = n_ef; ed = n_ed;
        push_cell(8, brd[17:16], win, ready_last, 1'b0);
    endtask

    task automatic apply(input vec_t v);
        if (v.rst) begin
            @(negedge ph1);
            reset = 1'b0; row_in = 2'b11; col_in = 2'b11; snap_ready = 1'b0;
            #1;
            chk("rst_bad", 32'(snap_bad), 32'd0);
        end else begin
            @(negedge ph1);
            row_in = v.row; col_in = v.col; xoro_in = v.xoro; win_in = v.win; snap_ready = v.ready;
            @(posedge ph1);
            #1;
        end
        chk("vec_valid", 32'(snap_valid), 32'(v.e_valid));
        chk("vec_board", 32'(snap_board), 32'(v.e_board));
        chk("vec_win",   32'(snap_win),   32'(v.e_win));
        chk("vec_err",   32'(seq_err),    32'(v.e_err));
        chk("vec_frame", 32'(frame_cnt),  32'(v.e_frame));
        chk("vec_drop",  32'(drop_cnt),   32'(v.e_drop));
        if (v.rst) begin
            @(negedge ph1);
            reset = 1'b1;
        end
    endtask

    // ---------------- hand-sequence helpers ----------------
    task automatic drive(input logic [1:0] row, input logic [1:0] col, input logic [1:0] x,
                         input logic [1:0] win, input bit ready);
        @(negedge ph1);
        row_in = row; col_in = col; xoro_in = x; win_in = win; snap_ready = ready;
        @(posedge ph1);
        #1;
    endtask

    task automatic drive_cell(input int idx, input logic [1:0] x, input logic [1:0] win, input bit ready);
        drive(2'(idx / 3), 2'(idx % 3), x, win, ready);
    endtask

    task automatic do_reset();
        @(negedge ph1);
        reset = 1'b0; row_in = 2'b11; col_in = 2'b11; snap_ready = 1'b0;
        @(negedge ph1);
        reset = 1'b1;
    endtask

    // ---------------- reference model ----------------
    logic [1:0]  m_cells[$];
    bit          m_valid;
    logic [17:0] m_board;
    logic [1:0]  m_win;
    bit          m_bad;
    bit          m_err;
    logic [7:0]  m_frames;
    int          m_drop;

    function automatic bit frame_inconsistent(input logic [17:0] brd, input logic [1:0] win);
        int nx = 0;
        int no = 0;
        int d;
        for (int i = 0; i < 9; i++) begin
            if (brd[2*i +: 2] == 2'b01) nx++;
            if (brd[2*i +: 2] == 2'b10) no++;
        end
        d = (nx > no) ? nx - no : no - nx;
        return (d > 1) || (win == 2'b01 && nx < 3) || (win == 2'b10 && no < 3);
    endfunction

    function automatic void model_reset();
        m_cells.delete();
        m_valid = 1'b0; m_board = '0; m_win = 2'b00; m_bad = 1'b0; m_err = 1'b0;
        m_frames = 8'd0; m_drop = 0;
    endfunction

    // The accepted prefix of the current frame is the queue; its length is the next index.
    function automatic void model_step(input logic [1:0] row, input logic [1:0] col,
                                       input logic [1:0] x, input logic [1:0] win, input bit ready);
        int idx;
        bit legal;
        bit consumed;
        logic [17:0] frame;
        consumed = m_valid && ready;
        m_err = 1'b0;
        if (row != 2'd3 && col != 2'd3) begin
            idx   = 3 * int'(row) + int'(col);
            legal = (x != 2'b11);
            if (m_cells.size() == 0) begin
                if (idx == 0 && legal) m_cells.push_back(x);
            end else if (idx == m_cells.size() && legal) begin
                m_cells.push_back(x);
            end else begin
                m_err = 1'b1;
                m_cells.delete();
                if (idx == 0 && legal) m_cells.push_back(x);
            end
            if (m_cells.size() == 9) begin
                for (int i = 0; i < 9; i++) frame[2*i +: 2] = m_cells[i];
                if (!m_valid || ready) begin
                    m_board  = frame;
                    m_win    = win;
`ifdef TTT_BOARD_RX_CHECK_EN
                    m_bad    = frame_inconsistent(frame, win);
`else
                    m_bad    = 1'b0;
`endif
                    m_valid  = 1'b1;
                    m_frames = m_frames + 8'd1;
                    consumed = 1'b0;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
                m_cells.delete();
            end
        end
        if (consumed) m_valid = 1'b0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit want_bad;
        int gen_idx;
        int r;
        logic [1:0] s_row, s_col, s_x, s_win;
        bit s_ready;

        board_a = 18'b01_10_01_10_01_10_01_10_01;
        board_b = 18'b10_00_01_10_10_01_00_01_10;
        board_x = 18'b01_01_01_01_01_01_01_01_01;

        // Clean frame, then consume it.
        push_rst();
        push_frame(board_a, 2'b01, 1'b0, 1'b1, board_a, 2'b01, 8'd1, 8'd0);
        push_idle(2'b11, 2'b11, 1'b0);
        ev = 1'b0;
        push_idle(2'b11, 2'b11, 1'b1);
        push_idle(2'b11, 2'b01, 1'b0);
        // Order error on cell 3, then a clean frame.
        push_rst();
        push_cell(0, 2'b01, 2'b00, 1'b0, 1'b0);
        push_cell(1, 2'b01, 2'b00, 1'b0, 1'b0);
        push_cell(3, 2'b10, 2'b00, 1'b0, 1'b1);
        push_frame(board_b, 2'b10, 1'b0, 1'b1, board_b, 2'b10, 8'd1, 8'd0);
        // Back-pressure: second frame dropped, then consume.
        push_rst();
        push_frame(board_a, 2'b01, 1'b0, 1'b1, board_a, 2'b01, 8'd1, 8'd0);
        push_frame(board_b, 2'b10, 1'b0, 1'b1, board_a, 2'b01, 8'd1, 8'd1);
        ev = 1'b0;
        push_idle(2'b11, 2'b11, 1'b1);
        // Consume and load on the same edge.
        push_rst();
        push_frame(board_a, 2'b01, 1'b0, 1'b1, board_a, 2'b01, 8'd1, 8'd0);
        push_frame(board_b, 2'b10, 1'b1, 1'b1, board_b, 2'b10, 8'd2, 8'd0);
        push_idle(2'b11, 2'b11, 1'b0);
        // Idle gaps, illegal code at index 4, discarded cell 5 while resyncing.
        push_rst();
        push_cell(0, 2'b01, 2'b00, 1'b0, 1'b0);
        push_idle(2'b11, 2'b00, 1'b0);
        push_cell(1, 2'b10, 2'b00, 1'b0, 1'b0);
        push_idle(2'b01, 2'b11, 1'b0);
        push_cell(2, 2'b01, 2'b00, 1'b0, 1'b0);
        push_cell(3, 2'b10, 2'b00, 1'b0, 1'b0);
        push_cell(4, 2'b11, 2'b00, 1'b0, 1'b1);
        push_cell(5, 2'b10, 2'b00, 1'b0, 1'b0);
        push_idle(2'b11, 2'b11, 1'b0);
        push_frame(board_a, 2'b01, 1'b0, 1'b1, board_a, 2'b01, 8'd1, 8'd0);

        reset = 1'b0;
        repeat (2) @(posedge ph1);
        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-frame clears everything asynchronously, no partial snapshot afterwards.
        do_reset();
        for (int i = 0; i < 9; i++) drive_cell(i, board_a[2*i +: 2], (i == 8) ? 2'b01 : 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) drive_cell(i, board_b[2*i +: 2], 2'b00, 1'b0);
        chk("mid_pre_valid", 32'(snap_valid), 32'd1);
        chk("mid_pre_frame", 32'(frame_cnt), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_valid", 32'(snap_valid), 32'd0);
        chk("mid_board", 32'(snap_board), 32'd0);
        chk("mid_win",   32'(snap_win),   32'd0);
        chk("mid_bad",   32'(snap_bad),   32'd0);
        chk("mid_err",   32'(seq_err),    32'd0);
        chk("mid_frame", 32'(frame_cnt),  32'd0);
        chk("mid_drop",  32'(drop_cnt),   32'd0);
        @(negedge ph1);
        reset = 1'b1;
        for (int i = 6; i < 9; i++) begin
            drive_cell(i, board_b[2*i +: 2], 2'b10, 1'b0);
            chk("post_err", 32'(seq_err), 32'd0);
        end
        chk("post_valid", 32'(snap_valid), 32'd0);
        chk("post_frame", 32'(frame_cnt), 32'd0);

        // All-X frame flagged only when the consistency check is built in.
        do_reset();
        for (int i = 0; i < 9; i++) drive_cell(i, board_x[2*i +: 2], (i == 8) ? 2'b01 : 2'b00, 1'b0);
`ifdef TTT_BOARD_RX_CHECK_EN
        want_bad = 1'b1;
`else
        want_bad = 1'b0;
`endif
        chk("allx_valid", 32'(snap_valid), 32'd1);
        chk("allx_bad",   32'(snap_bad),   32'(want_bad));
        for (int i = 0; i < 9; i++) drive_cell(i, board_a[2*i +: 2], (i == 8) ? 2'b01 : 2'b00, i == 8);
        chk("cons_board", 32'(snap_board), 32'(board_a));
        chk("cons_bad",   32'(snap_bad),   32'd0);

        // Drop counter saturation.
        do_reset();
        for (int f = 0; f < 258; f++)
            for (int i = 0; i < 9; i++) drive_cell(i, board_a[2*i +: 2], (i == 8) ? 2'b01 : 2'b00, 1'b0);
        chk("sat_drop",  32'(drop_cnt),   32'd255);
        chk("sat_frame", 32'(frame_cnt),  32'd1);
        chk("sat_board", 32'(snap_board), 32'(board_a));
        drive(2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
        chk("sat_consume", 32'(snap_valid), 32'd0);

        // Randomized scans against the model.
        do_reset();
        model_reset();
        gen_idx = 0;
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 99));
            s_win = 2'($urandom_range(0, 3));
            s_ready = ($urandom_range(0, 99) < 45);
            if (r < 8) begin
                if ($urandom_range(0, 1) == 0) begin
                    s_row = 2'b11; s_col = 2'($urandom_range(0, 3));
                end else begin
                    s_row = 2'($urandom_range(0, 2)); s_col = 2'b11;
                end
                s_x = 2'($urandom_range(0, 3));
            end else if (r < 12) begin
                s_row = 2'($urandom_range(0, 2)); s_col = 2'($urandom_range(0, 2));
                s_x = 2'($urandom_range(0, 3));
            end else if (r < 14) begin
                s_row = 2'(gen_idx / 3); s_col = 2'(gen_idx % 3); s_x = 2'b11;
            end else begin
                s_row = 2'(gen_idx / 3); s_col = 2'(gen_idx % 3);
                s_x = 2'($urandom_range(0, 2));
                gen_idx = (gen_idx + 1) % 9;
            end
            @(negedge ph1);
            row_in = s_row; col_in = s_col; xoro_in = s_x; win_in = s_win; snap_ready = s_ready;
            model_step(s_row, s_col, s_x, s_win, s_ready);
            @(posedge ph1);
            #1;
            chk("rnd_valid", 32'(snap_valid), 32'(m_valid));
            chk("rnd_board", 32'(snap_board), 32'(m_board));
            chk("rnd_win",   32'(snap_win),   32'(m_win));
            chk("rnd_bad",   32'(snap_bad),   32'(m_bad));
            chk("rnd_err",   32'(seq_err),    32'(m_err));
            chk("rnd_frame", 32'(frame_cnt),  32'(m_frames));
            chk("rnd_drop",  32'(drop_cnt),   32'(m_drop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ttt_board_rx.md
Name: ttt_board_rx

Overview:
- Receiving end of the tictactoe core's board-scan output stream (xoro_out, row_out, col_out, win).
- Watches the row-major cell scan, rebuilds a 3x3 shadow board, and checks scan order and cell codes.
- Hands each complete, validated frame to a downstream consumer (display / host bridge) through a valid/ready snapshot register.
- Sits directly after the tictactoe core and is the reader for that core's writer.

Parameters:
- CNT_W, 8, width of the frame counter and the dropped-frame counter.

Ports:
- ph1  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low (asserted at 0); released synchronously to ph1 upstream.
- xoro_in  input  2  cell code from the core: 00 empty, 01 X, 10 O, 11 illegal.
- row_in  input  2  scanned cell row 0..2; 3 = idle, no cell this cycle.
- col_in  input  2  scanned cell column 0..2; 3 = idle.
- win_in  input  2  core win flag (00 none, 01 X, 10 O, 11 draw), sampled with cell (2,2).
- snap_valid  output  1  snapshot register holds an unconsumed frame.
- snap_ready  input  1  consumer accepts the snapshot when snap_valid && snap_ready.
- snap_board  output  18  frame; cell (r,c) at bits [2*(3r+c)+1 : 2*(3r+c)].
- snap_win  output  2  win_in captured with cell (2,2).
- snap_bad  output  1  consistency flag (optional feature).
- seq_err  output  1  one-cycle pulse on an out-of-order cell or xoro=11.
- frame_cnt  output  CNT_W  count of frames delivered to the snapshot register; wraps.
- drop_cnt  output  CNT_W  count of frames lost because the snapshot was full; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state=SYNC, expected index=0, shadow board=0, snap_valid=0, snap_board=0, snap_win=0, snap_bad=0, seq_err=0, frame_cnt=0, drop_cnt=0.
- Cell index = 3*row_in + col_in. A cycle with row_in=3 or col_in=3 is idle and is ignored in every state; no error.

SYNC:
- Wait for a cell at (0,0) with xoro_in != 11.
- On that cell, write the shadow entry, set expected index=1, go to COLLECT.
- Any other cell is discarded silently; no seq_err.

COLLECT, non-idle cell:
- Index == expected and xoro_in != 11: write the shadow entry, expected index += 1.
- Index != expected, or xoro_in == 11: seq_err=1 for one cycle, shadow cleared, go to SYNC.
  - If the bad cell is a legal (0,0), it is consumed as a fresh start: write the shadow entry, expected=1, stay in COLLECT.

Frame completion (valid cell (2,2)), same edge:
- If snap_valid=0, or snap_valid && snap_ready this cycle:
  - snap_board <= shadow with the (2,2) entry merged in; snap_win <= win_in; snap_valid=1; frame_cnt += 1.
  - Latency: the last cell appears on snap_board one cycle later.
- Else (snapshot full and not being consumed): frame dropped, drop_cnt += 1 saturating, snapshot unchanged.
- Either way: shadow cleared, state=SYNC.

Handshake:
- snap_valid && snap_ready with no load on the same edge: snap_valid <= 0.
- snap_board holds its value until the next load.
- snap_board and snap_win are stable while snap_valid=1.

Boundaries:
- Back-to-back frames with no idle cycles are legal; the (0,0) right after (2,2) is accepted in the same edge's SYNC.
- Reset asserted mid-frame aborts the frame; no partial snapshot is ever presented.

Optional Feature:
- Macro TTT_BOARD_RX_CHECK_EN.
- Defined: on load, count X (01) and O (10) cells in the completed frame.
  - snap_bad=1 if |X-O| > 1, or if snap_win=01/10 while the winner's count is < 3.
  - snap_bad is loaded with snap_board and covered by the same valid.
- Not defined: snap_bad tied to 0; no counting logic synthesized.

Decomposition:
- Package ttt_pkg:
  - cell_t enum: EMPTY=2'b00, X=2'b01, O=2'b10, BAD=2'b11.
  - win_t enum: NONE=2'b00, XWIN=2'b01, OWIN=2'b10, DRAW=2'b11.
  - rx_state_t: SYNC, COLLECT.
  - Constants NCELLS=9, IDLE_RC=2'b11.
- One sub-module, ttt_board_check: combinational X/O counter and win consistency check, instantiated only under TTT_BOARD_RX_CHECK_EN.

Test Plan:
- Clean frame: scan X,O,X,O,X,O,X,O,X at indices 0..8, snap_ready=0, win_in=01 at (2,2).
  - One cycle later: snap_valid=1, snap_board=18'b01_10_01_10_01_10_01_10_01 (cell 8 in MSBs), snap_win=01, frame_cnt=1.
- Order error: cells 0,1,3.
  - seq_err pulses on the cell-3 cycle.
  - The following frame 0..8 delivers normally with no stale entries from the aborted one; frame_cnt=1.
- Back-pressure: two consecutive clean frames, snap_ready=0 throughout.
  - First frame is held, drop_cnt=1, frame_cnt=1.
  - Raise snap_ready for one cycle: snap_valid=0.
- Simultaneous: snap_ready=1 on the same edge as the second frame's (2,2).
  - Second frame loads, snap_valid stays 1, drop_cnt=0, frame_cnt=2.
- Idle gaps and illegal code: row_in=3 cycles between cells leave results unchanged; xoro_in=11 at index 4 gives seq_err=1, state=SYNC.
- Reset mid-frame: reset=0 after cell 5.
  - All outputs return to 0 immediately (asynchronous), with no snapshot.
  - With TTT_BOARD_RX_CHECK_EN defined, an all-X frame yields snap_bad=1.
